// File: rtl/cla_carry_pipe.sv
// Two-level carry-lookahead resolver for bit-level p/g vectors, behind a
// 2-stage valid/ready pipeline (S1: group P/G, S2: carries, sum, word P/G).
module cla_carry_pipe #(
   parameter int WIDTH = 8,
   parameter int GROUP = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] p,
   input  logic [WIDTH-1:0] g,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic [WIDTH-1:0] carry,
   output logic             cout,
   output logic             p_all,
   output logic             g_all
);
   localparam int NG = WIDTH / GROUP;

   if (WIDTH % GROUP != 0) begin : g_bad_width
      $error("cla_carry_pipe: WIDTH must be a multiple of GROUP");
   end

   logic             r_s1_v, r_s2_v;
   logic [WIDTH-1:0] r_s1_p, r_s1_g;
   logic             r_s1_cin;
   logic [NG-1:0]    r_s1_pg, r_s1_gg;
   logic [WIDTH-1:0] r_sum, r_carry;
   logic             r_cout, r_pall, r_gall;

   logic             w_s2_accept, w_in_xfer, w_s1_move, w_out_xfer;
   logic [NG-1:0]    w_pg, w_gg;
   logic [NG:0]      w_cg;
   logic [WIDTH:0]   w_c;
   logic             w_gall;

   assign w_s2_accept = !r_s2_v | out_ready;
   assign in_ready    = !r_s1_v | w_s2_accept;
   assign w_in_xfer   = in_valid & in_ready;
   assign w_s1_move   = r_s1_v & w_s2_accept;
   assign w_out_xfer  = r_s2_v & out_ready;

   // Group P/G: GG[k] is the OR-of-ANDs over the group, no internal ripple.
   always_comb begin : c_grp
      logic w_t;
      w_pg = '0;
      w_gg = '0;
      w_t  = 1'b0;
      for (int k = 0; k < NG; k++) begin
         w_pg[k] = &p[k*GROUP +: GROUP];
         for (int j = 0; j < GROUP; j++) begin
            w_t = g[k*GROUP+j];
            for (int m = j + 1; m < GROUP; m++) w_t = w_t & p[k*GROUP+m];
            w_gg[k] = w_gg[k] | w_t;
         end
      end
   end

   // Group carries and bit carries, each a flat sum of products.
   always_comb begin : c_carry
      logic w_t;
      w_cg   = '0;
      w_c    = '0;
      w_gall = 1'b0;
      w_t    = 1'b0;
      for (int k = 0; k <= NG; k++) begin
         w_t = r_s1_cin;
         for (int m = 0; m < k; m++) w_t = w_t & r_s1_pg[m];
         w_cg[k] = w_t;
         for (int j = 0; j < k; j++) begin
            w_t = r_s1_gg[j];
            for (int m = j + 1; m < k; m++) w_t = w_t & r_s1_pg[m];
            w_cg[k] = w_cg[k] | w_t;
         end
      end
      for (int j = 0; j < NG; j++) begin
         w_t = r_s1_gg[j];
         for (int m = j + 1; m < NG; m++) w_t = w_t & r_s1_pg[m];
         w_gall = w_gall | w_t;
      end
      for (int k = 0; k < NG; k++) begin
         for (int i = 0; i < GROUP; i++) begin
            w_t = w_cg[k];
            for (int m = 0; m < i; m++) w_t = w_t & r_s1_p[k*GROUP+m];
            w_c[k*GROUP+i] = w_t;
            for (int j = 0; j < i; j++) begin
               w_t = r_s1_g[k*GROUP+j];
               for (int m = j + 1; m < i; m++) w_t = w_t & r_s1_p[k*GROUP+m];
               w_c[k*GROUP+i] = w_c[k*GROUP+i] | w_t;
            end
         end
      end
      w_c[WIDTH] = w_cg[NG];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_v <= 1'b0;
         r_s2_v <= 1'b0;
      end else begin
         if (w_in_xfer)      r_s1_v <= 1'b1;
         else if (w_s1_move) r_s1_v <= 1'b0;
         if (w_s1_move)       r_s2_v <= 1'b1;
         else if (w_out_xfer) r_s2_v <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_p   <= '0;
         r_s1_g   <= '0;
         r_s1_cin <= 1'b0;
         r_s1_pg  <= '0;
         r_s1_gg  <= '0;
      end else if (w_in_xfer) begin
         r_s1_p   <= p;
         r_s1_g   <= g;
         r_s1_cin <= cin;
         r_s1_pg  <= w_pg;
         r_s1_gg  <= w_gg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum   <= '0;
         r_carry <= '0;
         r_cout  <= 1'b0;
         r_pall  <= 1'b0;
         r_gall  <= 1'b0;
      end else if (w_s1_move) begin
         r_sum   <= r_s1_p ^ w_c[WIDTH-1:0];
         r_carry <= w_c[WIDTH-1:0];
         r_cout  <= w_c[WIDTH];
         r_pall  <= &r_s1_pg;
         r_gall  <= w_gall;
      end
   end

   assign out_valid = r_s2_v;
   assign sum       = r_sum;
   assign carry     = r_carry;
   assign cout      = r_cout;
   assign p_all     = r_pall;
   assign g_all     = r_gall;
endmodule

// File: tb/tb_cla_carry_pipe.sv
// Bench for cla_carry_pipe (WIDTH=8, GROUP=4): directed vectors, backpressure,
// streaming and mid-flight reset against a ripple reference with a result queue.
module tb_cla_carry_pipe;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, in_ready, cin, out_valid, out_ready;
   logic [W-1:0] p, g, sum, carry;
   logic         cout, p_all, g_all;
   logic [18:0]  obs;

   int           total = 0;
   int           bad   = 0;
   int           nouts = 0;
   logic [18:0]  expq[$];

   cla_carry_pipe #(.WIDTH(W), .GROUP(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .p(p), .g(g), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .carry(carry), .cout(cout), .p_all(p_all), .g_all(g_all)
   );

   always #5 clk = ~clk;
   assign obs = {sum, carry, cout, p_all, g_all};

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   // Ripple evaluation of c[i+1] = g[i] | p[i]&c[i]; g_all reruns it with cin=0.
   function automatic logic [18:0] model(input logic [W-1:0] pp, input logic [W-1:0] gg,
                                         input logic ci);
      logic [W:0] c, c0;
      c[0]  = ci;
      c0[0] = 1'b0;
      for (int i = 0; i < W; i++) begin
         c[i+1]  = gg[i] | (pp[i] & c[i]);
         c0[i+1] = gg[i] | (pp[i] & c0[i]);
      end
      return {pp ^ c[W-1:0], c[W-1:0], c[W], &pp, c0[W]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   // One clock: drive at posedge+1, score transfers, advance to next posedge+1.
   task automatic step(input logic v, input logic [W-1:0] pi, input logic [W-1:0] gi,
                       input logic ci, input logic ordy, output logic acc);
      in_valid = v; p = pi; g = gi; cin = ci; out_ready = ordy;
      #1;
      acc = in_valid & in_ready;
      if (out_valid && out_ready) begin
         nouts++;
         chk("out_expected", 32'(expq.size() != 0), 1);
         if (expq.size() != 0) chk("result", obs, expq.pop_front());
      end
      if (acc) expq.push_back(model(pi, gi, ci));
      @(posedge clk);
      #1;
   endtask

   task automatic rnd(output logic [W-1:0] pr, output logic [W-1:0] gr, output logic cr);
      logic [W-1:0] a, b;
      a  = W'($urandom);
      b  = W'($urandom);
      pr = a ^ b;
      gr = a & b;
      cr = 1'($urandom);
   endtask

   task automatic run_one(input string tag, input logic [W-1:0] pi, input logic [W-1:0] gi,
                          input logic ci, input logic [18:0] exp_o);
      logic acc;
      step(1'b1, pi, gi, ci, 1'b1, acc);
      chk({tag, "_acc"}, 32'(acc), 1);
      chk({tag, "_lat1"}, 32'(out_valid), 0);
      step(1'b0, '0, '0, 1'b0, 1'b1, acc);
      chk({tag, "_lat2"}, 32'(out_valid), 1);
      chk({tag, "_val"}, obs, exp_o);
      step(1'b0, '0, '0, 1'b0, 1'b1, acc);
   endtask

   initial begin
      logic         acc;
      logic [W-1:0] wp[4], wg[4], rp, rg;
      logic         wc[4], rc;
      logic [18:0]  snap;
      int           idx, n0;

      rst_n = 1'b0; in_valid = 1'b0; p = '0; g = '0; cin = 1'b0; out_ready = 1'b0;
      snap = '0;
      #3;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_outputs", obs, 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      #4 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // directed vectors
      run_one("add5A3C", 8'h66, 8'h18, 1'b0, {8'h96, 8'hF0, 1'b0, 1'b0, 1'b0});
      run_one("allprop", 8'hFF, 8'h00, 1'b1, {8'h00, 8'hFF, 1'b1, 1'b1, 1'b0});
      run_one("topgen",  8'h00, 8'h80, 1'b0, {8'h00, 8'h00, 1'b1, 1'b0, 1'b1});

      // backpressure: out_ready low for 5 cycles
      for (int i = 0; i < 4; i++) rnd(wp[i], wg[i], wc[i]);
      idx = 0;
      for (int c = 0; c < 5; c++) begin
         if (c == 2) snap = obs;
         step(idx < 4, wp[idx%4], wg[idx%4], wc[idx%4], 1'b0, acc);
         if (acc) idx++;
      end
      chk("bp_accepts", 32'(idx), 2);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_hold", obs, snap);
      for (int c = 0; c < 20 && !(idx == 4 && expq.size() == 0); c++) begin
         step(idx < 4, wp[idx%4], wg[idx%4], wc[idx%4], 1'b1, acc);
         if (acc) idx++;
      end
      chk("bp_all_sent", 32'(idx), 4);
      chk("bp_drained", 32'(expq.size()), 0);

      // streaming at full rate
      n0 = nouts;
      for (int i = 0; i < 22; i++) begin
         chk("stream_ov", 32'(out_valid), (i >= 2) ? 1 : 0);
         if (i < 20) begin
            rnd(rp, rg, rc);
            step(1'b1, rp, rg, rc, 1'b1, acc);
            chk("stream_acc", 32'(acc), 1);
         end else begin
            step(1'b0, '0, '0, 1'b0, 1'b1, acc);
         end
      end
      chk("stream_count", 32'(nouts - n0), 20);
      chk("stream_drained", 32'(expq.size()), 0);

      // reset with two words in flight
      for (int i = 0; i < 2; i++) begin
         rnd(rp, rg, rc);
         step(1'b1, rp, rg, rc, 1'b0, acc);
      end
      in_valid = 1'b0;
      chk("mid_full", 32'(out_valid & ~in_ready), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_ov", 32'(out_valid), 0);
      chk("mid_rst_outputs", obs, 0);
      chk("mid_rst_in_ready", 32'(in_ready), 1);
      #2 rst_n = 1'b1;
      expq.delete();
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) begin
         chk("post_rst_idle", 32'(out_valid), 0);
         step(1'b0, '0, '0, 1'b0, 1'b1, acc);
      end
      rnd(rp, rg, rc);
      run_one("post_rst_word", rp, rg, rc, model(rp, rg, rc));
      chk("final_drained", 32'(expq.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
